// File: rtl/mseq_pkg.sv
`default_nettype none
// ============================================================================
// mseq_pkg: shared encodings and condition evaluation for micro_sequencer.
// Rev 1.0
// ============================================================================
package mseq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_W    = 5;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100,
    OP_DECODE = 3'b101,
    OP_WAIT   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  localparam logic [2:0] CS_ONE = 3'd0;
  localparam logic [2:0] CS_Z   = 3'd1;
  localparam logic [2:0] CS_N   = 3'd2;
  localparam logic [2:0] CS_C   = 3'd3;
  localparam logic [2:0] CS_V   = 3'd4;

  // flags are packed {Z,N,C,V}; selects 5..7 read as constant 0
  function automatic logic cond_eval(input logic [2:0] sel, input logic inv,
                                     input logic [3:0] flags);
    logic r;
    case (sel)
      CS_ONE:  r = 1'b1;
      CS_Z:    r = flags[3];
      CS_N:    r = flags[2];
      CS_C:    r = flags[1];
      CS_V:    r = flags[0];
      default: r = 1'b0;
    endcase
    return r ^ inv;
  endfunction

endpackage : mseq_pkg
`default_nettype wire

// File: rtl/mseq_stack.sv
`default_nettype none
// ============================================================================
// mseq_stack: parameterised LIFO return-address stack; entries persist on pop.
// Rev 1.0
// ============================================================================
module mseq_stack
  import mseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_top,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_W-1:0] o_depth
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;
  logic [PTR_W-1:0]   w_wr_idx;
  logic [PTR_W-1:0]   w_rd_idx;

  // read index wraps correctly when a power-of-two stack is full
  assign w_wr_idx = depth_q[PTR_W-1:0];
  assign w_rd_idx = w_wr_idx - PTR_W'(1);

  assign o_full  = (depth_q == DEPTH_W'(DEPTH));
  assign o_empty = (depth_q == '0);
  assign o_depth = depth_q;
  assign o_top   = mem_q[w_rd_idx];

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (i_push && !o_full) begin
      mem_d[w_wr_idx] = i_data;
      depth_d         = depth_q + DEPTH_W'(1);
    end else if (i_pop && !o_empty) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : mseq_stack
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// micro_sequencer: registered next-microaddress generator for the control store.
// Optional return stack enabled by defining MSEQ_CALLSTACK_EN.  Rev 1.0
// ============================================================================
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         Type_IN,
  input  logic [ADDR_W-1:0]  DAdd_IN,
  input  logic [ADDR_W-1:0]  MAP_IN,
  input  logic [3:0]         FLAGS_IN,
  input  logic               MEM_BUSY_IN,
  input  logic               STALL_IN,
  output logic [ADDR_W-1:0]  MPC_OUT,
  output logic               ERR_OUT,
  output logic [DEPTH_W-1:0] DEPTH_OUT
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16) begin : g_bad_depth
    $error("micro_sequencer: STACK_DEPTH must be in 2..16");
  end

  logic [ADDR_W-1:0] mpc_q;
  logic [ADDR_W-1:0] mpc_d;
  logic              err_q;
  logic              err_d;
  op_e               w_op;
  logic              w_cond;
  logic [ADDR_W-1:0] w_mpc_inc;

  assign w_op      = op_e'(Type_IN[6:4]);
  assign w_cond    = cond_eval(Type_IN[2:0], Type_IN[3], FLAGS_IN);
  assign w_mpc_inc = mpc_q + ADDR_W'(1);

`ifdef MSEQ_CALLSTACK_EN
  logic              w_push;
  logic              w_pop;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic [ADDR_W-1:0] w_stk_top;

  mseq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_mpc_inc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty),
    .o_depth (DEPTH_OUT)
  );
`else
  assign DEPTH_OUT = '0;
`endif

  always_comb begin
    mpc_d = mpc_q;
    err_d = err_q;
`ifdef MSEQ_CALLSTACK_EN
    w_push = 1'b0;
    w_pop  = 1'b0;
`endif
    if (!STALL_IN) begin
      case (w_op)
        OP_NEXT:   mpc_d = w_mpc_inc;
        OP_JUMP:   mpc_d = DAdd_IN;
        OP_BRANCH: mpc_d = w_cond ? DAdd_IN : w_mpc_inc;
        OP_CALL: begin
          // an overflowing call still jumps; only the return address is lost
          mpc_d = DAdd_IN;
`ifdef MSEQ_CALLSTACK_EN
          if (w_stk_full) begin
            err_d = 1'b1;
          end else begin
            w_push = 1'b1;
          end
`endif
        end
        OP_RET: begin
`ifdef MSEQ_CALLSTACK_EN
          if (w_stk_empty) begin
            mpc_d = '0;
            err_d = 1'b1;
          end else begin
            mpc_d = w_stk_top;
            w_pop = 1'b1;
          end
`else
          mpc_d = '0;
          err_d = 1'b1;
`endif
        end
        OP_DECODE: mpc_d = MAP_IN;
        OP_WAIT:   mpc_d = MEM_BUSY_IN ? mpc_q : w_mpc_inc;
        default: begin
          mpc_d = w_mpc_inc;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mpc_q <= '0;
      err_q <= 1'b0;
    end else begin
      mpc_q <= mpc_d;
      err_q <= err_d;
    end
  end

  assign MPC_OUT = mpc_q;
  assign ERR_OUT = err_q;

endmodule : micro_sequencer
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// tb_micro_sequencer: directed vectors with hand-computed expected values.
// Rev 1.0
// ============================================================================
module tb_micro_sequencer;
  import mseq_pkg::*;

`ifdef MSEQ_CALLSTACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] Type_IN = '0;
  logic [9:0] DAdd_IN = '0;
  logic [9:0] MAP_IN = '0;
  logic [3:0] FLAGS_IN = '0;
  logic       MEM_BUSY_IN = 1'b0;
  logic       STALL_IN = 1'b0;
  logic [9:0] MPC_OUT;
  logic       ERR_OUT;
  logic [4:0] DEPTH_OUT;

  int n_total = 0;
  int n_bad   = 0;

  micro_sequencer #(.STACK_DEPTH(4), .ADDR_W(10)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Type_IN     (Type_IN),
    .DAdd_IN     (DAdd_IN),
    .MAP_IN      (MAP_IN),
    .FLAGS_IN    (FLAGS_IN),
    .MEM_BUSY_IN (MEM_BUSY_IN),
    .STALL_IN    (STALL_IN),
    .MPC_OUT     (MPC_OUT),
    .ERR_OUT     (ERR_OUT),
    .DEPTH_OUT   (DEPTH_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic inv, input logic [2:0] sel,
                      input logic [9:0] dadd);
    Type_IN = {op, inv, sel};
    DAdd_IN = dadd;
    @(posedge CLK);
    #1;
  endtask

  task automatic jmp(input logic [9:0] a);
    step(OP_JUMP, 1'b0, 3'd0, a);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(OP_NEXT, 1'b0, 3'd0, 10'h000);
    RST = 1'b0;
  endtask

  logic [9:0] ret_mpc [5];
  logic [4:0] ret_dep [5];

  initial begin
    // reset held two cycles with a JUMP presented
    RST = 1'b1;
    step(OP_JUMP, 1'b0, 3'd0, 10'h155);
    step(OP_JUMP, 1'b0, 3'd0, 10'h155);
    chk("rst_mpc", MPC_OUT, 10'h000);
    chk("rst_err", ERR_OUT, 1'b0);
    chk("rst_depth", DEPTH_OUT, 5'd0);
    RST = 1'b0;
    step(OP_JUMP, 1'b0, 3'd0, 10'h155);
    chk("rel_jump", MPC_OUT, 10'h155);

    // branches
    jmp(10'h010);
    FLAGS_IN = 4'b1000;
    step(OP_BRANCH, 1'b0, CS_Z, 10'h080);
    chk("br_z1", MPC_OUT, 10'h080);
    jmp(10'h010);
    FLAGS_IN = 4'b0000;
    step(OP_BRANCH, 1'b0, CS_Z, 10'h080);
    chk("br_z0", MPC_OUT, 10'h011);
    jmp(10'h010);
    step(OP_BRANCH, 1'b1, CS_Z, 10'h080);
    chk("br_inv_z0", MPC_OUT, 10'h080);
    FLAGS_IN = 4'b0010;
    step(OP_BRANCH, 1'b0, CS_C, 10'h0C0);
    chk("br_c1", MPC_OUT, 10'h0C0);
    step(OP_BRANCH, 1'b0, 3'd6, 10'h000);
    chk("br_false", MPC_OUT, 10'h0C1);
    step(OP_BRANCH, 1'b1, 3'd5, 10'h1F0);
    chk("br_inv_false", MPC_OUT, 10'h1F0);
    FLAGS_IN = 4'b0000;

    // call / return
    jmp(10'h020);
    step(OP_CALL, 1'b0, 3'd0, 10'h100);
    chk("call_mpc", MPC_OUT, 10'h100);
    chk("call_depth", DEPTH_OUT, STK ? 5'd1 : 5'd0);
    step(OP_NEXT, 1'b0, 3'd0, 10'h000);
    chk("call_next", MPC_OUT, 10'h101);
    step(OP_RET, 1'b0, 3'd0, 10'h000);
    chk("ret_mpc", MPC_OUT, STK ? 10'h021 : 10'h000);
    chk("ret_depth", DEPTH_OUT, 5'd0);
    chk("ret_err", ERR_OUT, STK ? 1'b0 : 1'b1);

    // stack limits from a clean reset
    do_reset();
    chk("rst2_err", ERR_OUT, 1'b0);
    chk("rst2_mpc", MPC_OUT, 10'h000);
    for (int i = 0; i < 5; i++) begin
      step(OP_CALL, 1'b0, 3'd0, 10'h200 + 10'(i * 16));
      chk($sformatf("ncall%0d_mpc", i), MPC_OUT, 10'h200 + 10'(i * 16));
      chk($sformatf("ncall%0d_depth", i), DEPTH_OUT,
          STK ? ((i < 4) ? 5'(i + 1) : 5'd4) : 5'd0);
      chk($sformatf("ncall%0d_err", i), ERR_OUT, (STK && i == 4) ? 1'b1 : 1'b0);
    end
    ret_mpc[0] = 10'h221; ret_mpc[1] = 10'h211; ret_mpc[2] = 10'h201;
    ret_mpc[3] = 10'h001; ret_mpc[4] = 10'h000;
    ret_dep[0] = 5'd3; ret_dep[1] = 5'd2; ret_dep[2] = 5'd1;
    ret_dep[3] = 5'd0; ret_dep[4] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      step(OP_RET, 1'b0, 3'd0, 10'h000);
      chk($sformatf("nret%0d_mpc", i), MPC_OUT, STK ? ret_mpc[i] : 10'h000);
      chk($sformatf("nret%0d_depth", i), DEPTH_OUT, STK ? ret_dep[i] : 5'd0);
    end
    chk("nret_err", ERR_OUT, 1'b1);

    // wait and stall
    do_reset();
    jmp(10'h040);
    MEM_BUSY_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(OP_WAIT, 1'b0, 3'd0, 10'h000);
      chk($sformatf("wait_busy%0d", i), MPC_OUT, 10'h040);
    end
    MEM_BUSY_IN = 1'b0;
    step(OP_WAIT, 1'b0, 3'd0, 10'h000);
    chk("wait_done", MPC_OUT, 10'h041);
    STALL_IN = 1'b1;
    jmp(10'h300);
    chk("stall_jump", MPC_OUT, 10'h041);
    step(OP_RSVD, 1'b0, 3'd0, 10'h000);
    chk("stall_rsvd_err", ERR_OUT, 1'b0);
    chk("stall_rsvd_mpc", MPC_OUT, 10'h041);
    step(OP_CALL, 1'b0, 3'd0, 10'h123);
    chk("stall_call_depth", DEPTH_OUT, 5'd0);
    STALL_IN = 1'b0;

    // wrap, decode, reserved
    jmp(10'h3FF);
    step(OP_NEXT, 1'b0, 3'd0, 10'h000);
    chk("wrap_mpc", MPC_OUT, 10'h000);
    chk("wrap_err", ERR_OUT, 1'b0);
    MAP_IN = 10'h2A0;
    step(OP_DECODE, 1'b0, 3'd0, 10'h000);
    chk("decode", MPC_OUT, 10'h2A0);
    step(OP_RSVD, 1'b0, 3'd0, 10'h000);
    chk("rsvd_mpc", MPC_OUT, 10'h2A1);
    chk("rsvd_err", ERR_OUT, 1'b1);
    step(OP_NEXT, 1'b0, 3'd0, 10'h000);
    chk("err_sticky", ERR_OUT, 1'b1);
    chk("sticky_mpc", MPC_OUT, 10'h2A2);

    // reset in the middle of a call chain leaves nothing to return to
    do_reset();
    step(OP_CALL, 1'b0, 3'd0, 10'h100);
    step(OP_CALL, 1'b0, 3'd0, 10'h180);
    RST = 1'b1;
    step(OP_JUMP, 1'b0, 3'd0, 10'h2F0);
    RST = 1'b0;
    chk("midrst_depth", DEPTH_OUT, 5'd0);
    chk("midrst_err", ERR_OUT, 1'b0);
    step(OP_RET, 1'b0, 3'd0, 10'h000);
    chk("midrst_ret_mpc", MPC_OUT, 10'h000);
    chk("midrst_ret_err", ERR_OUT, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_micro_sequencer
`default_nettype wire
